// File: rtl/sram_march_bist.sv
// March-style SRAM self-test: four ascending passes (write pat, verify pat,
// write ~pat, verify ~pat) with pat(a) = a ^ seed, driven through a simple
// request/ready SRAM controller. Miscompares are counted and the first one
// is captured; the run always completes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no run since reset, waiting for start
// ISSUE   | waiting for ready, then a one-cycle mem request
// WAIT_LO | gives the controller one cycle to drop ready
// WAIT_HI | waiting for ready to return (access finished)
// CHECK   | compare read data, then advance address/pass
// ADV     | advance address/pass after a write
// DONE    | run finished, status and error capture held
module sram_march_bist #(
    parameter int              ADDR_W    = 19,
    parameter int              DATA_W    = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              mem,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_f2s,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_s2f,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_got,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_LO, WAIT_HI, CHECK, ADV, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        pass_q, pass_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;
    logic [DATA_W-1:0] err_got_q, err_got_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] exp_data;
    logic              do_adv;

    // pass[0] = read pass, pass[1] = inverted pattern
    assign pat      = DATA_W'(addr_q) ^ seed_q;
    assign exp_data = pass_q[1] ? ~pat : pat;

    assign addr     = addr_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign fail     = fail_q;
    assign err_addr = err_addr_q;
    assign err_exp  = err_exp_q;
    assign err_got  = err_got_q;
    assign err_cnt  = err_cnt_q;

    // Next-state, request outputs and error bookkeeping
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        seed_d     = seed_q;
        fail_d     = fail_q;
        err_addr_d = err_addr_q;
        err_exp_d  = err_exp_q;
        err_got_d  = err_got_q;
        err_cnt_d  = err_cnt_q;
        mem        = 1'b0;
        rw         = 1'b1;
        data_f2s   = '0;
        do_adv     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    fail_d     = 1'b0;
                    err_addr_d = '0;
                    err_exp_d  = '0;
                    err_got_d  = '0;
                    err_cnt_d  = '0;
                    seed_d     = seed;
                    addr_d     = '0;
                    pass_d     = 2'd0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (ready) begin
                    mem      = 1'b1;
                    rw       = pass_q[0];
                    data_f2s = pass_q[0] ? '0 : exp_data;
                    state_d  = WAIT_LO;
                end
            end
            WAIT_LO: state_d = WAIT_HI;
            WAIT_HI: begin
                if (ready) begin
                    state_d = pass_q[0] ? CHECK : ADV;
                end
            end
            CHECK: begin
                // Compare and advance in the same cycle to keep read spacing
                // equal to write spacing.
                if (data_s2f != exp_data) begin
                    fail_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (!fail_q) begin
                        err_addr_d = addr_q;
                        err_exp_d  = exp_data;
                        err_got_d  = data_s2f;
                    end
                end
                do_adv = 1'b1;
            end
            ADV:     do_adv = 1'b1;
            default: state_d = IDLE;
        endcase

        if (do_adv) begin
            if (addr_q < LAST_ADDR) begin
                addr_d  = addr_q + 1'b1;
                state_d = ISSUE;
            end else begin
                addr_d = '0;
                if (pass_q != 2'd3) begin
                    pass_d  = pass_q + 2'd1;
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    // State and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pass_q     <= 2'd0;
            seed_q     <= '0;
            fail_q     <= 1'b0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            seed_q     <= seed_d;
            fail_q     <= fail_d;
            err_addr_q <= err_addr_d;
            err_exp_q  <= err_exp_d;
            err_got_q  <= err_got_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
module tb_sram_march_bist;

    typedef struct packed {
        logic        rw;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } req_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // 8-address instance with a behavioural controller model
    logic       start_a;
    logic [7:0] seed_a;
    logic       mem_a, rw_a, ready_a;
    logic [7:0] addr_a, dout_a, din_a;
    logic       busy_a, done_a, fail_a;
    logic [7:0] err_addr_a, err_exp_a, err_got_a, err_cnt_a;

    // 256-address instance whose controller always reads back 0x00
    logic       start_s;
    logic [7:0] seed_s;
    logic       mem_s, rw_s, ready_s;
    logic [7:0] addr_s, dout_s, din_s;
    logic       busy_s, done_s, fail_s;
    logic [7:0] err_addr_s, err_exp_s, err_got_s, err_cnt_s;

    assign din_s = 8'h00;

    sram_march_bist #(.ADDR_W(8), .DATA_W(8), .LAST_ADDR(8'd7)) dut (
        .clk(clk), .reset(reset), .start(start_a), .seed(seed_a),
        .mem(mem_a), .rw(rw_a), .addr(addr_a), .data_f2s(dout_a),
        .ready(ready_a), .data_s2f(din_a),
        .busy(busy_a), .done(done_a), .fail(fail_a),
        .err_addr(err_addr_a), .err_exp(err_exp_a), .err_got(err_got_a),
        .err_cnt(err_cnt_a)
    );

    sram_march_bist #(.ADDR_W(8), .DATA_W(8), .LAST_ADDR(8'd255)) dut_sat (
        .clk(clk), .reset(reset), .start(start_s), .seed(seed_s),
        .mem(mem_s), .rw(rw_s), .addr(addr_s), .data_f2s(dout_s),
        .ready(ready_s), .data_s2f(din_s),
        .busy(busy_s), .done(done_s), .fail(fail_s),
        .err_addr(err_addr_s), .err_exp(err_exp_s), .err_got(err_got_s),
        .err_cnt(err_cnt_s)
    );

    int   busy_cyc = 2;
    bit   bp_en    = 1'b0;
    bit   stuck_en = 1'b0;
    logic [7:0] mem_arr [256];
    int   cnt_a;
    req_t log_a [$];
    int   viol_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model A: ready low busy_cyc cycles per access (+10 with backpressure)
    always @(posedge clk) begin
        if (reset) begin
            ready_a <= 1'b1;
            cnt_a   <= 0;
            din_a   <= 8'h00;
        end else if (start_a && bp_en && !busy_a) begin
            ready_a <= 1'b0;
            cnt_a   <= 10;
        end else if (mem_a && ready_a) begin
            ready_a <= 1'b0;
            cnt_a   <= busy_cyc + (bp_en ? 10 : 0);
            if (!rw_a) mem_arr[addr_a] <= dout_a;
            else if (stuck_en && addr_a == 8'd5) din_a <= mem_arr[addr_a] & 8'hFE;
            else din_a <= mem_arr[addr_a];
        end else if (!ready_a) begin
            if (cnt_a > 1) cnt_a <= cnt_a - 1;
            else ready_a <= 1'b1;
        end
    end

    // Controller model S: one busy cycle per access
    always @(posedge clk) begin
        if (reset) ready_s <= 1'b1;
        else if (mem_s && ready_s) ready_s <= 1'b0;
        else ready_s <= 1'b1;
    end

    // Request log and protocol monitor for instance A
    always @(negedge clk) begin
        if (mem_a) begin
            log_a.push_back('{rw: rw_a, addr: addr_a, data: dout_a, cyc: cyc});
            if (!ready_a) viol_a = viol_a + 1;
        end
    end

    function automatic logic [16:0] exp_req(input int i, input logic [7:0] sd);
        int p;
        logic [7:0] a, pt, d;
        p  = i / 8;
        a  = 8'(i % 8);
        pt = a ^ sd;
        case (p)
            0:       d = pt;
            2:       d = ~pt;
            default: d = 8'h00;
        endcase
        return {(p == 1 || p == 3), a, d};
    endfunction

    task automatic pulse_start_a(input logic [7:0] sd);
        @(negedge clk);
        start_a = 1'b1;
        seed_a  = sd;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done_a === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start_a = 1'b0; seed_a = 8'h00; start_s = 1'b0; seed_s = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if ({mem_a, rw_a, addr_a, dout_a} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
            errors++; $display("FAIL reset_req got %05h exp %05h", {mem_a, rw_a, addr_a, dout_a}, 18'h10000);
        end
        checks++; if ({busy_a, done_a, fail_a} !== 3'b000) begin
            errors++; $display("FAIL reset_status got %03b exp 000", {busy_a, done_a, fail_a});
        end
        checks++; if ({err_addr_a, err_exp_a, err_got_a, err_cnt_a} !== 32'h0) begin
            errors++; $display("FAIL reset_err got %08h exp 00000000", {err_addr_a, err_exp_a, err_got_a, err_cnt_a});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({mem_a, busy_a} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset got %02b exp 00", {mem_a, busy_a});
        end
    endtask

    task automatic test_clean_run;
        int base, maxgap;
        logic [16:0] got;
        busy_cyc = 2; bp_en = 1'b0; stuck_en = 1'b0;
        base = log_a.size();
        pulse_start_a(8'h5A);
        wait_done_a(1000);
        checks++; if ({done_a, fail_a, busy_a} !== 3'b100) begin
            errors++; $display("FAIL clean_status got %03b exp 100", {done_a, fail_a, busy_a});
        end
        checks++; if (err_cnt_a !== 8'd0) begin
            errors++; $display("FAIL clean_err_cnt got %0d exp 0", err_cnt_a);
        end
        checks++; if (log_a.size() - base != 32) begin
            errors++; $display("FAIL clean_req_count got %0d exp 32", log_a.size() - base);
        end
        if (log_a.size() >= base + 32) begin
            maxgap = 0;
            for (int i = 0; i < 32; i++) begin
                got = {log_a[base+i].rw, log_a[base+i].addr, log_a[base+i].data};
                checks++; if (got !== exp_req(i, 8'h5A)) begin
                    errors++; $display("FAIL clean_req[%0d] got %05h exp %05h", i, got, exp_req(i, 8'h5A));
                end
                if (i > 0 && int'(log_a[base+i].cyc - log_a[base+i-1].cyc) > maxgap)
                    maxgap = int'(log_a[base+i].cyc - log_a[base+i-1].cyc);
            end
            checks++; if (log_a[base+3].data !== 8'h59) begin
                errors++; $display("FAIL clean_addr3_p0 got %02h exp 59", log_a[base+3].data);
            end
            checks++; if (maxgap > 5 || maxgap < 1) begin
                errors++; $display("FAIL clean_req_spacing got %0d exp 1..5", maxgap);
            end
        end
    endtask

    task automatic test_stuck_bit;
        stuck_en = 1'b1;
        pulse_start_a(8'h5A);
        wait_done_a(1000);
        checks++; if ({done_a, fail_a} !== 2'b11) begin
            errors++; $display("FAIL stuck_status got %02b exp 11", {done_a, fail_a});
        end
        checks++; if ({err_addr_a, err_exp_a, err_got_a} !== 24'h055F5E) begin
            errors++; $display("FAIL stuck_capture got %06h exp 055f5e", {err_addr_a, err_exp_a, err_got_a});
        end
        checks++; if (err_cnt_a !== 8'd1) begin
            errors++; $display("FAIL stuck_err_cnt got %0d exp 1", err_cnt_a);
        end
        repeat (10) @(negedge clk);
        checks++; if ({done_a, fail_a, err_addr_a, err_cnt_a} !== {2'b11, 8'h05, 8'h01}) begin
            errors++; $display("FAIL done_hold got %05h exp 30501", {done_a, fail_a, err_addr_a, err_cnt_a});
        end
    endtask

    task automatic test_restart_clears;
        stuck_en = 1'b0;
        pulse_start_a(8'h5A);
        checks++; if ({busy_a, fail_a, err_addr_a, err_exp_a, err_got_a, err_cnt_a} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL restart_clear got %09h exp 200000000",
                               {busy_a, fail_a, err_addr_a, err_exp_a, err_got_a, err_cnt_a});
        end
        wait_done_a(1000);
        checks++; if ({done_a, fail_a} !== 2'b10) begin
            errors++; $display("FAIL restart_status got %02b exp 10", {done_a, fail_a});
        end
    endtask

    task automatic test_backpressure;
        int base, vbase;
        logic [16:0] got;
        bp_en = 1'b1;
        base  = log_a.size();
        vbase = viol_a;
        pulse_start_a(8'h5A);
        wait_done_a(3000);
        checks++; if (viol_a != vbase) begin
            errors++; $display("FAIL bp_mem_while_not_ready got %0d exp 0", viol_a - vbase);
        end
        checks++; if ({done_a, fail_a, err_cnt_a} !== {2'b10, 8'h00}) begin
            errors++; $display("FAIL bp_status got %03h exp 200", {done_a, fail_a, err_cnt_a});
        end
        checks++; if (log_a.size() - base != 32) begin
            errors++; $display("FAIL bp_req_count got %0d exp 32", log_a.size() - base);
        end
        if (log_a.size() >= base + 32) begin
            for (int i = 0; i < 32; i++) begin
                got = {log_a[base+i].rw, log_a[base+i].addr, log_a[base+i].data};
                checks++; if (got !== exp_req(i, 8'h5A)) begin
                    errors++; $display("FAIL bp_req[%0d] got %05h exp %05h", i, got, exp_req(i, 8'h5A));
                end
            end
        end
        bp_en = 1'b0;
    endtask

    task automatic test_start_while_busy;
        int base;
        logic [16:0] got;
        base = log_a.size();
        pulse_start_a(8'h5A);
        repeat (12) @(negedge clk);
        pulse_start_a(8'h33);
        wait_done_a(1000);
        checks++; if (log_a.size() - base != 32) begin
            errors++; $display("FAIL busy_start_req_count got %0d exp 32", log_a.size() - base);
        end
        if (log_a.size() >= base + 32) begin
            for (int i = 0; i < 32; i += 5) begin
                got = {log_a[base+i].rw, log_a[base+i].addr, log_a[base+i].data};
                checks++; if (got !== exp_req(i, 8'h5A)) begin
                    errors++; $display("FAIL busy_start_req[%0d] got %05h exp %05h", i, got, exp_req(i, 8'h5A));
                end
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int base, n;
        bit reached;
        logic [16:0] got;
        stuck_en = 1'b1;
        base = log_a.size();
        pulse_start_a(8'h5A);
        reached = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (log_a.size() - base >= 17) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!reached) begin
            errors++; $display("FAIL reach_p2 got %0d reqs exp 17", log_a.size() - base);
        end
        checks++; if (fail_a !== 1'b1) begin
            errors++; $display("FAIL pre_reset_fail got %b exp 1", fail_a);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({mem_a, busy_a, addr_a} !== 10'h0) begin
            errors++; $display("FAIL reset_mid_run got %03h exp 000", {mem_a, busy_a, addr_a});
        end
        checks++; if ({fail_a, err_addr_a, err_cnt_a} !== 17'h0) begin
            errors++; $display("FAIL reset_mid_err got %05h exp 00000", {fail_a, err_addr_a, err_cnt_a});
        end
        reset    = 1'b0;
        stuck_en = 1'b0;
        n = log_a.size();
        repeat (20) @(negedge clk);
        checks++; if (log_a.size() != n || busy_a !== 1'b0) begin
            errors++; $display("FAIL no_req_after_reset got %0d reqs busy %b exp 0 reqs busy 0", log_a.size() - n, busy_a);
        end
        pulse_start_a(8'h21);
        wait_done_a(1000);
        checks++; if (log_a.size() - n != 32) begin
            errors++; $display("FAIL rerun_req_count got %0d exp 32", log_a.size() - n);
        end
        if (log_a.size() > n) begin
            got = {log_a[n].rw, log_a[n].addr, log_a[n].data};
            checks++; if (got !== 17'h00021) begin
                errors++; $display("FAIL rerun_first_req got %05h exp 00021", got);
            end
        end
        checks++; if ({done_a, fail_a, err_cnt_a} !== {2'b10, 8'h00}) begin
            errors++; $display("FAIL rerun_status got %03h exp 200", {done_a, fail_a, err_cnt_a});
        end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        start_s = 1'b1;
        seed_s  = 8'h00;
        @(negedge clk);
        start_s = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done_s === 1'b1) break;
            @(negedge clk);
        end
        checks++; if ({done_s, fail_s} !== 2'b11) begin
            errors++; $display("FAIL sat_status got %02b exp 11", {done_s, fail_s});
        end
        checks++; if (err_cnt_s !== 8'd255) begin
            errors++; $display("FAIL sat_err_cnt got %0d exp 255", err_cnt_s);
        end
        checks++; if ({err_addr_s, err_exp_s, err_got_s} !== 24'h010100) begin
            errors++; $display("FAIL sat_capture got %06h exp 010100", {err_addr_s, err_exp_s, err_got_s});
        end
    endtask

    initial begin
        test_reset;
        test_clean_run;
        test_stuck_bit;
        test_restart_clears;
        test_backpressure;
        test_start_while_busy;
        test_saturation;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
